align_shift: RTL and testbench

- Multi-cycle exponent-alignment unit (denormalizer). It is the inverse of the post-operation normalizer.
- Right-shifts a mantissa (hidden bit plus guard/round/sticky) so that its exponent equals a target exponent. The sticky bit collapses into the LSB.
- Sits ahead of the add/sub datapath: the operand with the smaller exponent is aligned to the larger one.
- Valid/ready handshake on both sides. Shifts at most SHIFT_STEP bits per cycle to bound barrel-shifter depth.

---
 rtl/align_shift_if.sv | 33 +++
 rtl/align_shift.sv | 138 +++++++++++++
 tb/tb_align_shift.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/align_shift_if.sv
// Operand/result bus of the exponent-alignment unit.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. The sender keeps valid and its data stable until that edge.
// The receiver may raise or lower ready freely. Ready may depend on the
// receiver's state only, never on valid.
interface align_shift_if #(
   parameter int MANTIS_SIZE = 26,
   parameter int EXP_SIZE    = 8
);
   logic                   in_valid;
   logic                   in_ready;
   logic [EXP_SIZE-1:0]    exp_in;
   logic [EXP_SIZE-1:0]    exp_target;
   logic [MANTIS_SIZE-1:0] mantis_in;
   logic                   out_valid;
   logic                   out_ready;
   logic [EXP_SIZE-1:0]    exp_out;
   logic [MANTIS_SIZE-1:0] mantis_out;
   logic                   align_err;

   // Upstream/downstream side: supplies operands, consumes results.
   modport master (
      output in_valid, exp_in, exp_target, mantis_in, out_ready,
      input  in_ready, out_valid, exp_out, mantis_out, align_err
   );

   // Alignment unit side.
   modport slave (
      input  in_valid, exp_in, exp_target, mantis_in, out_ready,
      output in_ready, out_valid, exp_out, mantis_out, align_err
   );
endinterface

// File: rtl/align_shift.sv
// Multi-cycle exponent-alignment (denormalizer) unit.
// Right-shifts an operand mantissa until its exponent matches a target
// exponent. Every bit shifted out is ORed into bit 0 (sticky). At most
// SHIFT_STEP bits are shifted per cycle, which bounds the shifter depth.
// FSM: IDLE accepts an operand, SHIFT walks the mantissa right, and HOLD
// presents the result until downstream takes it.
module align_shift #(
   parameter int MANTIS_SIZE = 26,
   parameter int EXP_SIZE    = 8,
   parameter int SHIFT_STEP  = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   align_shift_if.slave bus,
   output logic [1:0]   state_dbg
);

   localparam int D_W = EXP_SIZE + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t                 state;
   logic [MANTIS_SIZE-1:0] work_mantis;
   logic [EXP_SIZE-1:0]    work_exp;
   logic [D_W-1:0]         remaining;

   logic [D_W-1:0]         diff;
   logic                   target_lt;
   logic                   diff_zero;
   logic                   diff_flush;
   logic [MANTIS_SIZE-1:0] flush_mantis;
   logic [D_W-1:0]         step;
   logic [MANTIS_SIZE-1:0] shift_mask;
   logic [MANTIS_SIZE-1:0] shifted;
   logic [MANTIS_SIZE-1:0] shift_next;
   logic [D_W-1:0]         rem_next;

   // Accept-time decode: distance to shift and which path to take.
   // diff has one extra bit, so its MSB flags exp_target < exp_in.
   always_comb begin
      diff         = {1'b0, bus.exp_target} - {1'b0, bus.exp_in};
      target_lt    = diff[D_W-1];
      diff_zero    = (diff == '0);
      diff_flush   = !target_lt && (diff >= D_W'(MANTIS_SIZE));
      flush_mantis = {{(MANTIS_SIZE-1){1'b0}}, |bus.mantis_in};
   end

   // One shift cycle: move right by min(remaining, SHIFT_STEP). Bits that
   // fall off the bottom, including the old bit 0, collapse into bit 0.
   always_comb begin
      step       = (remaining > D_W'(SHIFT_STEP)) ? D_W'(SHIFT_STEP) : remaining;
      shift_mask = ~({MANTIS_SIZE{1'b1}} << step);
      shifted    = work_mantis >> step;
      shift_next = {shifted[MANTIS_SIZE-1:1],
                    shifted[0] | (|(work_mantis & shift_mask))};
      rem_next   = remaining - step;
   end

   // Ready only while idle and out of reset, so nothing is taken during
   // SHIFT/HOLD or in the same cycle a result is released.
   assign bus.in_ready = rst_n && (state == IDLE);
   assign state_dbg    = state;

   // Control FSM plus datapath registers. The result registers are written
   // only on entry to HOLD, so they keep their last value at all other times.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         work_mantis    <= '0;
         work_exp       <= '0;
         remaining      <= '0;
         bus.out_valid  <= 1'b0;
         bus.exp_out    <= '0;
         bus.mantis_out <= '0;
         bus.align_err  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  if (target_lt) begin
                     // Target below operand: cannot align by right shift.
                     // Pass the operand through and flag it.
                     bus.exp_out    <= bus.exp_in;
                     bus.mantis_out <= bus.mantis_in;
                     bus.align_err  <= 1'b1;
                     bus.out_valid  <= 1'b1;
                     state          <= HOLD;
                  end else if (diff_zero) begin
                     bus.exp_out    <= bus.exp_in;
                     bus.mantis_out <= bus.mantis_in;
                     bus.align_err  <= 1'b0;
                     bus.out_valid  <= 1'b1;
                     state          <= HOLD;
                  end else if (diff_flush) begin
                     // Every bit would be shifted out: only the sticky bit remains.
                     bus.exp_out    <= bus.exp_target;
                     bus.mantis_out <= flush_mantis;
                     bus.align_err  <= 1'b0;
                     bus.out_valid  <= 1'b1;
                     state          <= HOLD;
                  end else begin
                     work_mantis <= bus.mantis_in;
                     work_exp    <= bus.exp_target;
                     remaining   <= diff;
                     state       <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               work_mantis <= shift_next;
               remaining   <= rem_next;
               if (rem_next == '0) begin
                  bus.exp_out    <= work_exp;
                  bus.mantis_out <= shift_next;
                  bus.align_err  <= 1'b0;
                  bus.out_valid  <= 1'b1;
                  state          <= HOLD;
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: begin
               bus.out_valid <= 1'b0;
               state         <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_align_shift.sv
// Bench for align_shift: directed steps plus random operands. Expected
// results and latencies go into queues when an operand is driven and are
// popped when the unit presents its result.
module tb_align_shift;

   localparam int MS = 26;
   localparam int ES = 8;
   localparam int RW = 1 + ES + MS;

   logic       clk;
   logic       rst_n;
   logic [1:0] state_dbg;

   align_shift_if #(.MANTIS_SIZE(MS), .EXP_SIZE(ES)) bus ();

   align_shift #(.MANTIS_SIZE(MS), .EXP_SIZE(ES), .SHIFT_STEP(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus.slave),
      .state_dbg (state_dbg)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [RW-1:0] exp_q[$];
   int            lat_q[$];
   int            cmp_cnt = 0;
   int            err_cnt = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      cmp_cnt++;
      assert (obs === expv) else begin
         err_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference: {align_err, exp_out, mantis_out} for one operand.
   function automatic logic [RW-1:0] model(input logic [ES-1:0] ei, input logic [ES-1:0] et,
                                           input logic [MS-1:0] m);
      int d;
      logic [MS-1:0] r;
      d = int'(et) - int'(ei);
      if (d < 0) return {1'b1, ei, m};
      if (d == 0) return {1'b0, ei, m};
      if (d >= MS) return {1'b0, et, {(MS-1){1'b0}}, |m};
      r = m >> d;
      for (int i = 0; i < d; i++) if (m[i]) r[0] = 1'b1;
      return {1'b0, et, r};
   endfunction

   function automatic int model_lat(input logic [ES-1:0] ei, input logic [ES-1:0] et);
      int d;
      d = int'(et) - int'(ei);
      if (d <= 0 || d >= MS) return 1;
      return 1 + (d + 3) / 4;
   endfunction

   // Driver: offer one operand, collect and compare the result, keep it
   // in HOLD for hold cycles (with ignored in_valid traffic), then release.
   task automatic run_op(input logic [ES-1:0] ei, input logic [ES-1:0] et,
                         input logic [MS-1:0] m, input logic [RW-1:0] expr,
                         input int exp_lat, input int hold);
      int            w;
      int            lat;
      logic [RW-1:0] obs;
      logic [RW-1:0] want;
      int            want_lat;
      exp_q.push_back(expr);
      lat_q.push_back(exp_lat);
      w = 0;
      while (!bus.in_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      check("in_ready_idle", 64'(bus.in_ready), 64'd1);
      bus.exp_in     = ei;
      bus.exp_target = et;
      bus.mantis_in  = m;
      bus.in_valid   = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid   = 1'b0;
      bus.exp_in     = ES'($urandom);
      bus.exp_target = ES'($urandom);
      bus.mantis_in  = MS'($urandom);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.out_valid && lat < 64);
      obs      = {bus.align_err, bus.exp_out, bus.mantis_out};
      want     = exp_q.pop_front();
      want_lat = lat_q.pop_front();
      check("result", 64'(obs), 64'(want));
      check("latency", 64'(lat), 64'(want_lat));
      check("in_ready_hold", 64'(bus.in_ready), 64'd0);
      for (int h = 0; h < hold; h++) begin
         bus.in_valid   = 1'b1;
         bus.exp_in     = ES'($urandom);
         bus.exp_target = ES'($urandom);
         bus.mantis_in  = MS'($urandom);
         @(negedge clk);
         check("hold_valid", 64'(bus.out_valid), 64'd1);
         check("hold_stable", 64'({bus.align_err, bus.exp_out, bus.mantis_out}), 64'(want));
         check("hold_in_ready", 64'(bus.in_ready), 64'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      check("valid_drop", 64'(bus.out_valid), 64'd0);
      check("ready_back", 64'(bus.in_ready), 64'd1);
      check("keep_last", 64'({bus.align_err, bus.exp_out, bus.mantis_out}), 64'(want));
   endtask

   task automatic run_model(input logic [ES-1:0] ei, input logic [ES-1:0] et,
                            input logic [MS-1:0] m, input int hold);
      run_op(ei, et, m, model(ei, et, m), model_lat(ei, et), hold);
   endtask

   initial begin
      logic [ES-1:0] ei;
      logic [ES-1:0] et;
      rst_n          = 1'b0;
      bus.in_valid   = 1'b0;
      bus.out_ready  = 1'b0;
      bus.exp_in     = '0;
      bus.exp_target = '0;
      bus.mantis_in  = '0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", 64'(bus.in_ready), 64'd0);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_outputs", 64'({bus.align_err, bus.exp_out, bus.mantis_out}), 64'd0);
      check("rst_state", 64'(state_dbg), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", 64'(bus.in_ready), 64'd1);

      // Directed steps with hand-derived expectations
      run_op(8'd10,  8'd10,  26'h2000001, {1'b0, 8'd10,  26'h2000001}, 1, 0);
      run_op(8'd100, 8'd105, 26'h2000000, {1'b0, 8'd105, 26'h0100000}, 3, 0);
      run_op(8'd20,  8'd24,  26'h2000028, {1'b0, 8'd24,  26'h0200003}, 2, 0);
      run_op(8'd50,  8'd80,  26'h0000004, {1'b0, 8'd80,  26'h0000001}, 1, 0);
      run_op(8'd50,  8'd80,  26'h0000000, {1'b0, 8'd80,  26'h0000000}, 1, 0);
      run_op(8'd0,   8'd0,   26'h0000000, {1'b0, 8'd0,   26'h0000000}, 1, 0);
      run_op(8'd0,   8'd25,  26'h3000000, {1'b0, 8'd25,  26'h0000001}, 8, 1);
      run_op(8'd0,   8'd26,  26'h2000000, {1'b0, 8'd26,  26'h0000001}, 1, 0);
      run_op(8'd3,   8'd4,   26'h0000003, {1'b0, 8'd4,   26'h0000001}, 2, 0);
      run_op(8'd255, 8'd254, 26'h0ABCDEF, {1'b1, 8'd255, 26'h0ABCDEF}, 1, 0);
      run_op(8'd9,   8'd5,   26'h1234567, {1'b1, 8'd9,   26'h1234567}, 1, 3);

      // Reset in the middle of a d=12 shift aborts it
      @(negedge clk);
      bus.exp_in     = 8'd40;
      bus.exp_target = 8'd52;
      bus.mantis_in  = 26'h3FFFFFF;
      bus.in_valid   = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("mid_shift_state", 64'(state_dbg), 64'd1);
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", 64'(bus.out_valid), 64'd0);
      check("abort_outputs", 64'({bus.align_err, bus.exp_out, bus.mantis_out}), 64'd0);
      check("abort_in_ready", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_ready_back", 64'(bus.in_ready), 64'd1);
      check("abort_no_result", 64'(bus.out_valid), 64'd0);
      run_op(8'd60, 8'd72, 26'h3FFFFFF, {1'b0, 8'd72, 26'h0003FFF}, 4, 0);

      // Random operands, targets clustered around the operand exponent
      for (int n = 0; n < 24; n++) begin
         ei = ES'($urandom_range(0, 255));
         et = ES'(int'(ei) + $urandom_range(0, 34) - 4);
         run_model(ei, et, MS'($urandom), $urandom_range(0, 2));
      end

      check("queue_drained", 64'(exp_q.size() + lat_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
